// File: rtl/zero_count_pkg.sv
// rtl/zero_count_pkg.sv - shared types and helpers for the sequential zero counter
//
// Purpose: FSM state and mode enumerations plus the count-width helper used
//          by zero_count_seq and its testbench.
// Contents:
//   zc_state_e    IDLE / SCAN / DONE
//   zc_mode_e     ZC_TRAILING (0) / ZC_LEADING (1)
//   zc_cnt_width  bits needed to hold a count of 0..w inclusive
package zero_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } zc_state_e;

    typedef enum logic {
        ZC_TRAILING = 1'b0,
        ZC_LEADING  = 1'b1
    } zc_mode_e;

    // A count can equal w itself (all-zero word), hence the extra bit.
    function automatic int zc_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/zc_chunk_tz.sv
// rtl/zc_chunk_tz.sv - combinational trailing-zero count of one chunk
//
// Purpose: trailing-zero count and nonzero flag for a CHUNK_WIDTH-bit slice.
// Ports:
//   data_i     in   CHUNK_WIDTH           chunk to examine
//   tz_o       out  $clog2(CHUNK_WIDTH)   trailing zeros (meaningful only when nonzero_o)
//   nonzero_o  out  1                     at least one bit of data_i is set
module zc_chunk_tz #(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0]         data_i,
    output logic [$clog2(CHUNK_WIDTH)-1:0] tz_o,
    output logic                           nonzero_o
);

    localparam int TZ_W = $clog2(CHUNK_WIDTH);

    // x & -x keeps only the lowest set bit, giving a one-hot vector whose
    // position is the trailing-zero count.
    logic [CHUNK_WIDTH-1:0] lowest_set;

    assign lowest_set = data_i & (~data_i + CHUNK_WIDTH'(1));
    assign nonzero_o  = |data_i;

    // One-hot to binary: bit b of the index is the OR of every one-hot
    // position whose own index has bit b set.
    always_comb begin
        tz_o = '0;
        for (int b = 0; b < TZ_W; b++) begin
            for (int i = 0; i < CHUNK_WIDTH; i++) begin
                if (((i >> b) & 1) == 1) begin
                    tz_o[b] = tz_o[b] | lowest_set[i];
                end
            end
        end
    end

endmodule

// File: rtl/zero_count_seq.sv
// rtl/zero_count_seq.sv - iterative handshaked trailing/leading zero counter
//
// Purpose: counts trailing (mode=0) or leading (mode=1) zeros of a word,
//          scanning CHUNK_WIDTH bits per cycle between valid/ready ports.
// Build option: ZERO_COUNT_EARLY_EXIT_EN - end the scan at the first nonzero
//          chunk instead of always visiting every chunk (results identical).
// Ports:
//   clk        in   1                      rising-edge clock
//   reset      in   1                      synchronous active-high reset
//   in_valid   in   1                      din/mode valid
//   in_ready   out  1                      idle, can accept a word
//   din        in   DATA_WIDTH             word to scan
//   mode       in   1                      0 trailing zeros, 1 leading zeros
//   out_valid  out  1                      result valid
//   out_ready  in   1                      consumer accepts result
//   dout       out  $clog2(DATA_WIDTH)+1   zero count 0..DATA_WIDTH
//   all_zero   out  1                      word had no set bit
module zero_count_seq
    import zero_count_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DATA_WIDTH):0]   dout,
    output logic                          all_zero
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int CNT_W      = zc_cnt_width(DATA_WIDTH);
    localparam int TZ_W       = $clog2(CHUNK_WIDTH);

`ifdef ZERO_COUNT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    zc_state_e              state_q;
    logic [DATA_WIDTH-1:0]  word_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       acc_q;
    logic                   found_q;
    logic [CNT_W-1:0]       dout_q;
    logic                   all_zero_q;
    logic                   out_valid_q;

    logic [DATA_WIDTH-1:0]  din_rev;
    logic [DATA_WIDTH-1:0]  word_d;
    logic [CHUNK_WIDTH-1:0] chunk;
    logic [TZ_W-1:0]        chunk_tz;
    logic                   chunk_nz;
    logic                   last_chunk;
    logic [CNT_W-1:0]       hit_d;
    logic                   first_hit;

    // Leading zeros of din are the trailing zeros of its mirror image, so
    // the word is reversed once on capture and a single scan path serves
    // both modes.
    always_comb begin
        din_rev = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            din_rev[i] = din[DATA_WIDTH-1-i];
        end
    end

    assign word_d     = (zc_mode_e'(mode) == ZC_LEADING) ? din_rev : din;
    assign chunk      = word_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));
    assign hit_d      = acc_q + CNT_W'(chunk_tz);
    assign first_hit  = !found_q && chunk_nz;

    zc_chunk_tz #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk_tz (
        .data_i    (chunk),
        .tz_o      (chunk_tz),
        .nonzero_o (chunk_nz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            found_q     <= 1'b0;
            dout_q      <= '0;
            all_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        word_q     <= word_d;
                        idx_q      <= '0;
                        acc_q      <= '0;
                        found_q    <= 1'b0;
                        dout_q     <= '0;
                        all_zero_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end

                SCAN: begin
                    // Once found_q is set the result is frozen; the
                    // remaining chunks are only walked for fixed latency.
                    if (first_hit) begin
                        dout_q  <= hit_d;
                        found_q <= 1'b1;
                    end else if (!found_q) begin
                        acc_q <= acc_q + CNT_W'(CHUNK_WIDTH);
                        if (last_chunk) begin
                            dout_q     <= CNT_W'(DATA_WIDTH);
                            all_zero_q <= 1'b1;
                        end
                    end

                    if (last_chunk || (EARLY_EXIT && first_hit)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign all_zero  = all_zero_q;

endmodule

// File: tb/tb_zero_count_seq.sv
// tb/tb_zero_count_seq.sv - self-checking bench for zero_count_seq
module tb_zero_count_seq;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NC = DW / CW;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] din;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    dout;
    logic          all_zero;

    int n_assert;
    int n_fail;

    zero_count_seq #(
        .DATA_WIDTH  (DW),
        .CHUNK_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .all_zero  (all_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the bits in scan order and stop at the first one.
    function automatic int ref_count(input logic [DW-1:0] w, input bit m);
        for (int i = 0; i < DW; i++) begin
            if ((m ? w[DW-1-i] : w[i]) == 1'b1) return i;
        end
        return DW;
    endfunction

    function automatic int ref_lat(input int cnt);
`ifdef ZERO_COUNT_EARLY_EXIT_EN
        if (cnt >= DW) return NC;
        return cnt / CW + 1;
`else
        return NC + 0 * cnt;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word, measure latency, optionally stall the consumer while
    // poking in_valid, then release and confirm the return to IDLE.
    task automatic run_word(input logic [DW-1:0] w, input bit m, input int stall);
        int exp_c;
        int exp_l;
        int cyc;
        exp_c = ref_count(w, m);
        exp_l = ref_lat(exp_c);
        chk("in_ready_before", {31'd0, in_ready}, 32'd1);
        din       = w;
        mode      = m;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        din      = $urandom;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, exp_l);
        chk("dout", {26'd0, dout}, exp_c);
        chk("all_zero", {31'd0, all_zero}, {31'd0, (exp_c == DW)});
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            din      = $urandom;
            mode     = $urandom_range(1, 0);
            tick();
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_dout", {26'd0, dout}, exp_c);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        logic [DW-1:0] w;
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_dout", {26'd0, dout}, 32'd0);
        chk("reset_all_zero", {31'd0, all_zero}, 32'd0);

        run_word(32'h0000_0100, 1'b0, 0);
        run_word(32'h0000_0000, 1'b0, 0);
        run_word(32'h0000_0000, 1'b1, 0);
        run_word(32'h0001_0000, 1'b1, 0);
        run_word(32'h8000_0000, 1'b1, 0);
        run_word(32'h0000_0001, 1'b0, 5);

        // Reset two cycles into SCAN of an all-zero word.
        din      = '0;
        mode     = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        in_valid = 1'b1;
        din      = 32'h0000_00FF;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_dout", {26'd0, dout}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        run_word(32'h8000_0000, 1'b0, 0);

        // Back-to-back with in_valid held high throughout.
        din       = 32'h0000_0010;
        mode      = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        din = 32'hFFFF_FFFF;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("b2b_first_latency", cyc, ref_lat(4));
        chk("b2b_first_dout", {26'd0, dout}, 32'd4);
        tick();
        chk("b2b_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("b2b_idle_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("b2b_second_latency", cyc, ref_lat(0));
        chk("b2b_second_dout", {26'd0, dout}, 32'd0);
        chk("b2b_second_all_zero", {31'd0, all_zero}, 32'd0);
        tick();

        // Random words with varying sparsity, modes and consumer stalls.
        for (int k = 0; k < 60; k++) begin
            w = $urandom;
            case ($urandom_range(3, 0))
                0: w = w & ($urandom & $urandom);
                1: w = w << $urandom_range(31, 0);
                2: w = w >> $urandom_range(31, 0);
                default: w = (k % 7 == 0) ? 32'h0 : w;
            endcase
            run_word(w, $urandom_range(1, 0), $urandom_range(2, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/zero_count_seq.md
# zero_count_seq

Iterative, handshaked zero counter that reports either the trailing-zero or the leading-zero count of a `DATA_WIDTH`-bit word. It is the sequential successor to the team's single-cycle combinational trailing-zero counter. It scans `CHUNK_WIDTH` bits per cycle, so wide words close timing. It sits between a valid/ready producer and consumer in datapath utilities: normalisation, priority selection and free-slot search.

## Interface
- `DATA_WIDTH`, 32, word width; must be a multiple of `CHUNK_WIDTH`
- `CHUNK_WIDTH`, 8, bits examined per scan cycle; power of two, at least 2
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `din`/`mode` valid
- `in_ready`  out  1  block can accept a word
- `din`  in  `DATA_WIDTH`  word to scan
- `mode`  in  1  0 = trailing zeros (from bit 0 up); 1 = leading zeros (from MSB down)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `dout`  out  `$clog2(DATA_WIDTH)+1`  zero count, range 0..`DATA_WIDTH`
- `all_zero`  out  1  `din` was all zeros (`dout` == `DATA_WIDTH`)

## Operation
- `NUM_CHUNKS` = `DATA_WIDTH`/`CHUNK_WIDTH`.
- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: capture `din`; if `mode`=1, bit-reverse it on capture so one trailing-zero path serves both modes.
  - Clear the chunk index and the accumulator, then go to SCAN.
- **SCAN**
  - Each cycle examines chunk[idx], bits idx·CW .. idx·CW+CW-1 of the captured word.
  - Uses a per-chunk trailing-zero count `tz` and a nonzero flag.
  - First nonzero chunk: result = acc + tz; the result is latched and frozen.
  - All-zero chunk: acc += `CHUNK_WIDTH`.
  - If no chunk is nonzero after the last chunk: result = `DATA_WIDTH`, `all_zero`=1.
- **DONE**
  - `out_valid`=1; `dout` and `all_zero` hold stable until `out_ready`, then go to IDLE.
- Only one word is in flight. `in_ready`=0 in SCAN and DONE; `in_valid` is ignored there.
- Arithmetic: the accumulator is `$clog2(DATA_WIDTH)+1` bits wide and never exceeds `DATA_WIDTH`. No wrap.
- Reset (any state, including mid-SCAN or DONE):
  - Next state IDLE; `out_valid`=0, `dout`=0, `all_zero`=0, accumulator and index cleared.
  - `in_ready`=1 from the cycle after the reset edge.
  - The in-flight word is dropped. Inputs sampled while `reset`=1 are ignored.

## Timing
- Accept edge E0: `in_valid`&&`in_ready`.
- `out_valid` rises L cycles after E0, where L depends on the configuration (see Configuration).
- Output handshake edge: `out_valid`&&`out_ready`. The block is in IDLE the following cycle, so at most one accept per L+2 cycles.
- A result is never presented combinationally from `din`; all outputs are registered.
- `in_ready` is a decode of the registered state only, with no dependence on `in_valid`.

## Configuration
- `ZERO_COUNT_EARLY_EXIT_EN` defined:
  - SCAN ends on the first nonzero chunk.
  - L = j+1, where j is the index of that chunk in scan order.
  - All-zero word: L = `NUM_CHUNKS`.
- Not defined:
  - SCAN always visits all chunks; the result freezes at the first nonzero chunk.
  - Fixed latency L = `NUM_CHUNKS` for every word.
- `dout` and `all_zero` values are identical in both builds.

## Structure
- Package `zero_count_pkg` holds:
  - `zc_state_e` (IDLE, SCAN, DONE)
  - `zc_mode_e` (ZC_TRAILING=0, ZC_LEADING=1)
  - a width function returning `$clog2(w)+1`
- Sub-module `zc_chunk_tz`: combinational, input `CHUNK_WIDTH` bits; outputs the trailing-zero count (`$clog2(CHUNK_WIDTH)` bits) and a `nonzero` flag. It uses the isolate-lowest-set-bit technique.
- Top level holds the FSM, capture/bit-reverse register, index and accumulator.

## Test plan
Defaults: `DATA_WIDTH`=32, `CHUNK_WIDTH`=8, `out_ready`=1 unless stated.
1. `din`=0x0000_0100, `mode`=0 -> `dout`=8, `all_zero`=0. L=2 with `ZERO_COUNT_EARLY_EXIT_EN`, 4 without.
2. `din`=0x0000_0000, `mode`=0 and `mode`=1 -> `dout`=32, `all_zero`=1, L=4 in both builds.
3. `mode`=1:
   - `din`=0x0001_0000 -> `dout`=15, L=2 (early exit).
   - `din`=0x8000_0000 -> `dout`=0, L=1.
4. Backpressure: `din`=0x0000_0001 with `out_ready`=0 for 5 cycles -> `dout`=0 held stable, `out_valid`=1 and `in_ready`=0 throughout. A new `in_valid` pulse is not accepted. Release -> IDLE next cycle.
5. Reset mid-operation: accept `din`=0, assert `reset` after 2 SCAN cycles -> `out_valid`=0, `dout`=0, `in_ready`=1 next cycle. Then `din`=0x8000_0000, `mode`=0 -> `dout`=31.
6. Back-to-back: words 0x0000_0010 then 0xFFFF_FFFF (`mode`=0) with `in_valid` held -> results 4 then 0. The second word is accepted exactly one cycle after the first output handshake.
